// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and a multi-cycle mult/div interlock.
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_md_start,
  input  logic        id_md_read,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        md_busy,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [7:0] CNT_INIT = 8'(MD_CYCLES - 1);

  md_state_t  state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_use;
  logic       md_hazard;
  logic       stall;

  always_comb begin
    load_use  = ex_memread && (ex_rt != 5'd0) &&
                ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    md_hazard = (state != IDLE) && (id_md_start || id_md_read);
    // A taken branch squashes the ID instruction, so any hazard it caused is moot.
    stall     = (load_use || md_hazard) && !ex_branch_taken;
  end

  assign pc_stall    = stall;
  assign if_id_stall = stall;
  assign if_id_flush = ex_branch_taken;
  assign id_ex_flush = ex_branch_taken || stall;
  assign md_busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Branch flushes do not abort an operation already past IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (id_md_start && !stall && !ex_branch_taken) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == 8'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      DONE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + 16'd1;
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned MDC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_use_rs, id_use_rt, id_md_start, id_md_read, ex_memread, ex_branch_taken;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, md_busy;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MD_CYCLES(MDC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_start(id_md_start), .id_md_read(id_md_read),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .md_busy(md_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Model state: cycles the mult/div unit will still be occupied, and event tallies.
  int unsigned md_left = 0;
  int unsigned m_stalls = 0;
  int unsigned m_flushes = 0;

  logic s_busy, s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_use_rs = 0; id_use_rt = 0; id_md_start = 0; id_md_read = 0;
    ex_memread = 0; ex_branch_taken = 0;
  endtask

  function automatic int unsigned cnt_exp(input int unsigned n);
`ifdef HAZARD_PERF_CNT_EN
    return (n > 65535) ? 65535 : n;
`else
    return 0;
`endif
  endfunction

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    logic lu, busy, mh, stl, br;
    int unsigned nl, ns, nf;
    #1;
    br   = ex_branch_taken;
    lu   = ex_memread && (ex_rt != 0) &&
           ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
    busy = (md_left > 0);
    mh   = busy && (id_md_start || id_md_read);
    stl  = (lu || mh) && !br;
    chk("pc_stall",    32'(pc_stall),    32'(stl));
    chk("if_id_stall", 32'(if_id_stall), 32'(stl));
    chk("if_id_flush", 32'(if_id_flush), 32'(br));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(br || stl));
    chk("md_busy",     32'(md_busy),     32'(busy));
    chk("stall_cnt",   32'(stall_cnt),   cnt_exp(m_stalls));
    chk("flush_cnt",   32'(flush_cnt),   cnt_exp(m_flushes));
    s_busy  = md_busy;
    s_stall = pc_stall;
    if (busy)                          nl = md_left - 1;
    else if (id_md_start && !stl && !br) nl = MDC + 1;
    else                               nl = 0;
    ns = m_stalls + (stl ? 1 : 0);
    nf = m_flushes + (br ? 1 : 0);
    @(posedge clk);
    #1;
    if (rst_n) begin
      md_left = nl; m_stalls = ns; m_flushes = nf;
    end else begin
      md_left = 0; m_stalls = 0; m_flushes = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    #1;
    md_left = 0; m_stalls = 0; m_flushes = 0;
    chk("rst_md_busy",   32'(md_busy),   32'd0);
    chk("rst_pc_stall",  32'(pc_stall),  32'd0);
    chk("rst_id_ex_fl",  32'(id_ex_flush), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned busy_cycles, stall_cycles;
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    do_reset();

    // Load-use on rs: one stall cycle, then the load has advanced.
    ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1;
    #1;
    chk("lu_pc_stall",    32'(pc_stall),    32'd1);
    chk("lu_if_id_stall", 32'(if_id_stall), 32'd1);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    tick();
    ex_memread = 0;
    #1;
    chk("lu_released", 32'(pc_stall), 32'd0);
    tick();

    // Same match against r0 never stalls; branch overrides a real hazard.
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1;
    #1;
    chk("lu_r0_no_stall", 32'(pc_stall), 32'd0);
    tick();
    ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1;
    #1;
    chk("br_pc_stall",    32'(pc_stall),    32'd0);
    chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
    chk("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
    tick();
    clear_inputs();
    tick();

    // Mult/div pulse: occupancy must be MD_CYCLES+1 cycles.
    id_md_start = 1;
    tick();
    id_md_start = 0;
    busy_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (s_busy) busy_cycles++;
    end
    chk("md_busy_len", busy_cycles, 32'd9);
    chk("md_idle_after", 32'(md_busy), 32'd0);

    // mfhi/mflo held while busy stalls until the unit is idle.
    id_md_start = 1;
    tick();
    id_md_start = 0; id_md_read = 1;
    stall_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_stall) stall_cycles++;
    end
    chk("md_read_stalls", stall_cycles, 32'd9);
    chk("md_read_release", 32'(pc_stall), 32'd0);
    clear_inputs();
    tick();

    // Asynchronous reset in the third BUSY cycle abandons the operation.
    id_md_start = 1;
    tick();
    id_md_start = 0;
    tick();
    tick();
    chk("md_busy_pre_rst", 32'(md_busy), 32'd1);
    do_reset();
    id_md_start = 1;
    tick();
    id_md_start = 0;
    busy_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (s_busy) busy_cycles++;
    end
    chk("md_restart_len", busy_cycles, 32'd9);

    // Performance counters: three load-use stalls and two branch flushes.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ex_memread = 1; ex_rt = 5'd7; id_rt = 5'd7; id_use_rt = 1;
      tick();
      clear_inputs();
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      ex_branch_taken = 1;
      tick();
      clear_inputs();
      tick();
    end
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("perf_flush_cnt", 32'(flush_cnt), 32'd2);
`else
    chk("perf_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("perf_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    @(negedge clk);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      ex_memread      = ($urandom_range(0, 2) == 0);
      id_md_start     = ($urandom_range(0, 9) == 0);
      id_md_read      = ($urandom_range(0, 5) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
